hex_display_bank: RTL
=====================

// Module: hex_display_bank
// PURPOSE
// - Registered driver for NUM_DIGITS seven-segment digits (DE1-SoC HEX0..HEX5 style, active-low segments).
// - Generalises the single-digit 4-bit to 7-segment decode:
//   - parametrised digit count;
//   - load/ack handshake and a shift-in entry mode;
//   - leading-zero blanking;
//   - per-digit blink;
//   - lamp-test mode.
// - Sits between datapath/FSM logic and the board HEX pins.
// PARAMETERS
// - NUM_DIGITS  6      number of digits; value width 4*NUM_DIGITS (legal 1..8)
// - BLINK_DIV   25000000  clock cycles per blink half-period (legal >=2)
// PORTS
// - clock       in   1      single clock; all state on rising edge
// - resetn      in   1      asynchronous, active-low reset
// - value_in    in   4*N    new display value, digit i = value_in[4i+3:4i]
// - load        in   1      load request, sampled every edge
// - load_ack    out  1      one-cycle pulse, edge after a load is accepted
// - mode        in   2      00 hex, 01 hex + leading-zero blank, 10 shift-in, 11 lamp test
// - blink_en    in   1      global blink enable
// - blink_mask  in   N      per-digit blink select
// - hex_out     out  7*N    digit i segments = hex_out[7i+6:7i], bit0=a..bit6=g, 0=lit
// BEHAVIOUR
// - Reset (async, resetn=0):
//   - display_reg=0, blink_cnt=0, blink_phase=0, load_ack=0;
//   - hex_out = all 1s (every segment dark).
// - Load:
//   - load is always accepted; there is no back-pressure.
//   - Modes 00/01/11: display_reg <= value_in.
//   - Mode 10: display_reg <= {display_reg[4N-5:0], value_in[3:0]}. Digit 0 gets the new nibble; the top digit is discarded.
//   - load_ack=1 in the cycle after each accepted load. Back-to-back loads give back-to-back acks.
// - Output register:
//   - hex_out is recomputed every edge from display_reg, mode, blink_phase and the masks.
//   - Latency: load sampled at edge k -> hex_out shows the new value after edge k+1.
//   - Mode/blink_en/blink_mask changes appear after the next edge (1 cycle).
// - Decode: active-low, standard 0-F:
//   - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//   - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex, bit6..bit0)
// - Leading-zero blank (mode 01):
//   - Digit i>0 is dark (7F) when digits i..N-1 are all 0.
//   - Digit 0 is never blanked, so value 0 shows a single "0".
// - Lamp test (mode 11): every digit 00 (all lit). Blink still applies.
// - Blink:
//   - blink_cnt counts 0..BLINK_DIV-1, wraps to 0 and toggles blink_phase on wrap.
//   - It runs continuously, independent of blink_en.
//   - A digit is forced dark when blink_en & blink_phase & blink_mask[i].
//   - Blanking priority: blink dark > leading-zero dark > decode.
// - Simultaneous events: a load and a blink_phase toggle on the same edge both take effect. The output after the next edge reflects both.
// - Reset mid-operation: outputs go dark immediately (async). After release, the first edge drives digit 0 = "0" (modes 00/01).
// STRUCTURE
// - Shared package hex_display_pkg:
//   - SEG_BLANK=7'h7F, SEG_ALL=7'h00;
//   - mode constants MODE_HEX, MODE_LZB, MODE_SHIFT, MODE_LAMP;
//   - the 16-entry segment table.
// - One sub-module, hex_seg_decoder: combinational 4-bit in, 7-bit active-low out, instantiated N times in a generate loop.
// - Top level holds display_reg, the blink counter, the leading-zero scan and the output register.
// TESTING (N=6, BLINK_DIV=4)
// - Reset:
//   - resetn=0 -> hex_out=all 1s.
//   - After release, one edge -> digit0=40, others=40 (mode 00).
// - Load:
//   - mode 00, load value_in=24'h0A3F19 -> load_ack one cycle later;
//   - after 2 edges, digits 5..0 = 40,08,30,0E,79,10.
// - Leading-zero blank: mode 01, value 24'h000120 -> digits 5..3 = 7F, digits 2..0 = 79,24,40; value 0 -> only digit0=40.
// - Shift-in:
//   - mode 10, reg=0, load nibbles 1,2,3 on consecutive cycles -> reg=24'h000123;
//   - after 7 shifts, the first 1 has fallen off the top.
// - Blink:
//   - blink_en=1, mask=6'b000001, value 24'h000005;
//   - digit0 alternates 12/7F every 4 cycles;
//   - other digits are unaffected; lamp test blinks the same way.
// - Reset mid-blink with a pending load: resetn low for 1 cycle -> all dark, load_ack=0, blink phase restarts at 0.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display bank: segment codes,
// display modes and the active-low 0-F glyph table.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ALL   = 7'h00;

    typedef enum logic [1:0] {
        MODE_HEX   = 2'b00,
        MODE_LZB   = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_LAMP  = 2'b11
    } mode_e;

    // Entry n is the glyph for nibble n; bit0 = segment a, 0 = lit.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_display_if.sv
// Load/ack handshake, display controls and segment outputs of the display bank.
interface hex_display_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    load_ack;
    logic [1:0]              mode;
    logic                    blink_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [7*NUM_DIGITS-1:0] hex_out;

    modport master (
        output value_in, load, mode, blink_en, blink_mask,
        input  load_ack, hex_out
    );

    modport slave (
        input  value_in, load, mode, blink_en, blink_mask,
        output load_ack, hex_out
    );
endinterface

// File: rtl/hex_seg_decoder.sv
// Combinational 4-bit to active-low 7-segment glyph decode for one digit.
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = seg_of(nibble);
endmodule

// File: rtl/hex_display_bank.sv
// Registered NUM_DIGITS seven-segment driver: value register with load or
// shift-in entry, leading-zero blanking, per-digit blink and lamp test.
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic         clock,
    input  logic         resetn,
    hex_display_if.slave bus
);
    localparam int VW    = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [VW-1:0]                 display_reg_q, display_reg_d;
    logic [CNT_W-1:0]              blink_cnt_q, blink_cnt_d;
    logic                          blink_phase_q, blink_phase_d;
    logic                          load_ack_q, load_ack_d;
    logic [NUM_DIGITS-1:0][6:0]    hex_out_q, hex_out_d;

    logic [VW-1:0]                 shift_val;
    logic [NUM_DIGITS-1:0][6:0]    seg_dec;
    logic [NUM_DIGITS-1:0]         nz_upper;
    logic                          nz_acc;
    mode_e                         mode_s;

    assign mode_s = mode_e'(bus.mode);

    // A one-digit bank has nothing to shift up; the new nibble simply replaces it.
    generate
        if (NUM_DIGITS == 1) begin : g_shift_one
            assign shift_val = bus.value_in[3:0];
        end else begin : g_shift_many
            assign shift_val = {display_reg_q[VW-5:0], bus.value_in[3:0]};
        end
    endgenerate

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
            hex_seg_decoder u_dec (
                .nibble (display_reg_q[4*g +: 4]),
                .seg    (seg_dec[g])
            );
        end
    endgenerate

    // nz_upper[i] is set when any digit from i up to the top is non-zero.
    always_comb begin
        nz_upper = '0;
        nz_acc   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_acc      = nz_acc | (|display_reg_q[4*i +: 4]);
            nz_upper[i] = nz_acc;
        end
    end

    always_comb begin
        display_reg_d = display_reg_q;
        if (bus.load) begin
            display_reg_d = (mode_s == MODE_SHIFT) ? shift_val : bus.value_in;
        end
        load_ack_d = bus.load;

        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Blink darkening wins over everything, lamp test and blanking next.
    always_comb begin
        hex_out_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.blink_en && blink_phase_q && bus.blink_mask[i]) begin
                hex_out_d[i] = SEG_BLANK;
            end else if (mode_s == MODE_LAMP) begin
                hex_out_d[i] = SEG_ALL;
            end else if (mode_s == MODE_LZB && i != 0 && !nz_upper[i]) begin
                hex_out_d[i] = SEG_BLANK;
            end else begin
                hex_out_d[i] = seg_dec[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            display_reg_q <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            load_ack_q    <= 1'b0;
            hex_out_q     <= '1;
        end else begin
            display_reg_q <= display_reg_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            load_ack_q    <= load_ack_d;
            hex_out_q     <= hex_out_d;
        end
    end

    assign bus.load_ack = load_ack_q;
    assign bus.hex_out  = hex_out_q;

endmodule
